// File: rtl/agu_stage_ctrl.sv
// Stage sequencer for the NWC address-generation path: runs the radix-k1 AGU once per
// k1 stage, then AGU_k2, then drains the pipeline. Optional watchdog: AGU_CTRL_WATCHDOG_EN.
module agu_stage_ctrl #(
  parameter int D_WIDTH       = 12,
  parameter int NUM_K1_STAGES = 3,
  parameter int DRAIN_CYCLES  = 4,
  parameter int WDT_LIMIT     = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               AGU_done_k1,
  input  logic               AGU_done_k2,
  output logic               AGU_enable_k1,
  output logic               AGU_enable_k2,
  output logic [D_WIDTH-1:0] l_k1,
  output logic               busy,
  output logic               ctrl_done,
  output logic               ctrl_err
);

  localparam int DCW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [D_WIDTH-1:0] K1_LAST = D_WIDTH'(NUM_K1_STAGES - 1);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    IDLE, RUN_K1, GAP, RUN_K2, DRAIN, DONE
  } state_e;

  state_e             state_q, state_d;
  logic [D_WIDTH-1:0] lk1_q, lk1_d;
  logic [DCW-1:0]     drain_q, drain_d;
  logic               en_k1_q, en_k2_q, busy_q, done_q;
  logic               err_q, err_d;
  logic               wdt_trip;

`ifdef AGU_CTRL_WATCHDOG_EN
  localparam int WCW = $clog2(WDT_LIMIT + 1);
  localparam logic [WCW-1:0] WDT_LAST = WCW'(WDT_LIMIT - 1);

  logic [WCW-1:0] wdt_q, wdt_d;

  // Counter is zero in every non-run state, so it is already clear on entry to a run state
  always_comb begin
    wdt_d = '0;
    if (state_q == RUN_K1 || state_q == RUN_K2) wdt_d = wdt_q + WCW'(1);
  end

  assign wdt_trip = (state_q == RUN_K1 && !AGU_done_k1 && wdt_q == WDT_LAST) ||
                    (state_q == RUN_K2 && !AGU_done_k2 && wdt_q == WDT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdt_q <= '0;
    else     wdt_q <= wdt_d;
  end
`else
  logic unused_wdt;
  assign unused_wdt = |WDT_LIMIT;
  assign wdt_trip   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    lk1_d   = lk1_q;
    drain_d = drain_q;
    err_d   = err_q;
    if (abort) begin
      state_d = IDLE;
      lk1_d   = '0;
      drain_d = '0;
    end else if (wdt_trip) begin
      state_d = IDLE;
      lk1_d   = '0;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          lk1_d = '0;
          if (start) begin
            err_d   = 1'b0;
            state_d = (NUM_K1_STAGES > 0) ? RUN_K1 : RUN_K2;
          end
        end
        RUN_K1: if (AGU_done_k1) state_d = GAP;
        GAP: begin
          if (lk1_q == K1_LAST) begin
            state_d = RUN_K2;
          end else begin
            lk1_d   = lk1_q + D_WIDTH'(1);
            state_d = RUN_K1;
          end
        end
        RUN_K2: begin
          if (AGU_done_k2) begin
            state_d = DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (drain_q == '0) state_d = DONE;
          else               drain_d = drain_q - DCW'(1);
        end
        DONE: begin
          state_d = IDLE;
          lk1_d   = '0;
        end
        default: begin
          state_d = IDLE;
          lk1_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they align with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lk1_q   <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
      en_k1_q <= 1'b0;
      en_k2_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lk1_q   <= lk1_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      en_k1_q <= (state_d == RUN_K1);
      en_k2_q <= (state_d == RUN_K2);
      busy_q  <= (state_d == RUN_K1) || (state_d == GAP) ||
                 (state_d == RUN_K2) || (state_d == DRAIN);
      done_q  <= (state_d == DONE);
    end
  end

  assign AGU_enable_k1 = en_k1_q;
  assign AGU_enable_k2 = en_k2_q;
  assign l_k1          = lk1_q;
  assign busy          = busy_q;
  assign ctrl_done     = done_q;
`ifdef AGU_CTRL_WATCHDOG_EN
  assign ctrl_err      = err_q;
`else
  assign ctrl_err      = 1'b0;
  logic unused_err;
  assign unused_err    = err_q;
`endif

endmodule

// File: tb/tb_agu_stage_ctrl.sv
// Directed bench for agu_stage_ctrl: a 2-stage/drain-3 instance and a k2-only/drain-0 instance.
module tb_agu_stage_ctrl;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst, abort;
  logic start, dk1, dk2;
  logic start0, dk1_0, dk2_0;
  logic en1, en2, busy, cdone, cerr;
  logic [DW-1:0] lk1;
  logic en1_0, en2_0, busy0, cdone0, cerr0;
  logic [DW-1:0] lk1_0;

  int checks = 0;
  int errors = 0;

  logic [16:0] obs, exp_v;

  agu_stage_ctrl #(.D_WIDTH(DW), .NUM_K1_STAGES(2), .DRAIN_CYCLES(3), .WDT_LIMIT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .AGU_done_k1(dk1), .AGU_done_k2(dk2),
    .AGU_enable_k1(en1), .AGU_enable_k2(en2), .l_k1(lk1),
    .busy(busy), .ctrl_done(cdone), .ctrl_err(cerr));

  agu_stage_ctrl #(.D_WIDTH(DW), .NUM_K1_STAGES(0), .DRAIN_CYCLES(0), .WDT_LIMIT(16)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort),
    .AGU_done_k1(dk1_0), .AGU_done_k2(dk2_0),
    .AGU_enable_k1(en1_0), .AGU_enable_k2(en2_0), .l_k1(lk1_0),
    .busy(busy0), .ctrl_done(cdone0), .ctrl_err(cerr0));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {en_k1, en_k2, busy, ctrl_done, ctrl_err, l_k1} for the 2-stage timeline with start at cycle 0
  function automatic logic [16:0] nominal(int c);
    logic e1, e2, b, d;
    logic [DW-1:0] l;
    e1 = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
    e2 = (c >= 11 && c <= 14);
    b  = (c >= 1 && c <= 18);
    d  = (c == 19);
    l  = (c >= 6 && c <= 19) ? DW'(1) : DW'(0);
    return {e1, e2, b, d, 1'b0, l};
  endfunction

  task automatic test_reset();
    rst = 1'b1; abort = 1'b0;
    start = 1'b0; dk1 = 1'b0; dk2 = 1'b0;
    start0 = 1'b0; dk1_0 = 1'b0; dk2_0 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    obs = {en1, en2, busy, cdone, cerr, lk1};
    checks++;
    if (obs !== 17'h0) begin
      errors++; $display("FAIL reset_main got=%h want=%h", obs, 17'h0);
    end
    obs = {en1_0, en2_0, busy0, cdone0, cerr0, lk1_0};
    checks++;
    if (obs !== 17'h0) begin
      errors++; $display("FAIL reset_k2only got=%h want=%h", obs, 17'h0);
    end
  endtask

  task automatic test_full_run();
    for (int c = 0; c <= 21; c++) begin
      start = (c == 0);
      dk1   = (c == 4) || (c == 9);
      dk2   = (c == 14);
      obs   = {en1, en2, busy, cdone, cerr, lk1};
      exp_v = nominal(c);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL full_run c=%0d got=%h want=%h", c, obs, exp_v);
      end
      tick();
    end
    start = 1'b0; dk1 = 1'b0; dk2 = 1'b0;
  endtask

  task automatic test_k2_only();
    logic [16:0] want [0:5];
    want[0] = 17'h0;
    want[1] = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0};
    want[2] = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0};
    want[3] = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0};
    want[4] = 17'h0;
    want[5] = 17'h0;
    for (int c = 0; c <= 5; c++) begin
      start0 = (c == 0);
      dk2_0  = (c == 1);
      obs    = {en1_0, en2_0, busy0, cdone0, cerr0, lk1_0};
      checks++;
      if (obs !== want[c]) begin
        errors++; $display("FAIL k2_only c=%0d got=%h want=%h", c, obs, want[c]);
      end
      tick();
    end
    start0 = 1'b0; dk2_0 = 1'b0;
  endtask

  task automatic test_abort();
    for (int c = 0; c <= 12; c++) begin
      start = (c == 0);
      dk1   = (c == 4) || (c == 7);
      abort = (c == 7);
      dk2   = (c == 10);
      obs   = {en1, en2, busy, cdone, cerr, lk1};
      exp_v = (c <= 7) ? nominal(c) : 17'h0;
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL abort c=%0d got=%h want=%h", c, obs, exp_v);
      end
      tick();
    end
    start = 1'b0; dk1 = 1'b0; dk2 = 1'b0; abort = 1'b0;
  endtask

  task automatic test_start_ignore();
    for (int c = 0; c <= 24; c++) begin
      start = (c == 0) || (c == 2) || (c == 19) || (c == 22);
      dk1   = (c == 4) || (c == 9);
      dk2   = (c == 3) || (c == 14);
      abort = (c == 23);
      obs   = {en1, en2, busy, cdone, cerr, lk1};
      if (c <= 20)      exp_v = nominal(c);
      else if (c == 23) exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0};
      else              exp_v = 17'h0;
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL start_ignore c=%0d got=%h want=%h", c, obs, exp_v);
      end
      tick();
    end
    start = 1'b0; dk1 = 1'b0; dk2 = 1'b0; abort = 1'b0;
  endtask

  task automatic test_async_rst();
    for (int c = 0; c <= 12; c++) begin
      start = (c == 0);
      dk1   = (c == 4) || (c == 9);
      if (c == 12) begin
        obs   = {en1, en2, busy, cdone, cerr, lk1};
        exp_v = nominal(12);
        checks++;
        if (obs !== exp_v) begin
          errors++; $display("FAIL async_rst_pre got=%h want=%h", obs, exp_v);
        end
      end
      if (c < 12) tick();
    end
    start = 1'b0; dk1 = 1'b0;
    #2 rst = 1'b1;
    #1;
    obs = {en1, en2, busy, cdone, cerr, lk1};
    checks++;
    if (obs !== 17'h0) begin
      errors++; $display("FAIL async_rst_now got=%h want=%h", obs, 17'h0);
    end
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      obs = {en1, en2, busy, cdone, cerr, lk1};
      checks++;
      if (obs !== 17'h0) begin
        errors++; $display("FAIL async_rst_post c=%0d got=%h want=%h", c, obs, 17'h0);
      end
    end
  endtask

`ifdef AGU_CTRL_WATCHDOG_EN
  task automatic test_watchdog();
    for (int c = 0; c <= 20; c++) begin
      start = (c == 0) || (c == 18);
      abort = (c == 19);
      obs   = {en1, en2, busy, cdone, cerr, lk1};
      if (c >= 1 && c <= 16)   exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0};
      else if (c == 17 || c == 18) exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0};
      else if (c == 19)        exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0};
      else                     exp_v = 17'h0;
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL watchdog c=%0d got=%h want=%h", c, obs, exp_v);
      end
      tick();
    end
    start = 1'b0; abort = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_run();
    test_k2_only();
    test_abort();
    test_start_ignore();
    test_async_rst();
`ifdef AGU_CTRL_WATCHDOG_EN
    test_watchdog();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
